// File: rtl/cache_pkg.sv
// Shared cache definitions: default geometry, line-port FSM state encoding and
// the word-index width helper used by the cache datapath and the RAM line port.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 8;
  localparam int unsigned LINE_WORDS_DEFAULT = 4;
  localparam int unsigned WORD_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2,
    StAck   = 2'd3
  } port_state_e;

  // Bits needed to index a word within a line (at least one).
  function automatic int unsigned word_idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ram_line_port_if.sv
// Bundle of the two buses around the RAM line port.
//   cache side : ram_avalid, ram_wr, ram_addr, ram_wdata -> ram_rdata, ram_ack
//   memory side: mem_req, mem_we, mem_addr, mem_wdata -> mem_ready, mem_rvalid, mem_rdata
// slave  = the line port itself; master = the cache plus external memory around it.
interface ram_line_port_if
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
);
  localparam int unsigned IDX_WIDTH = word_idx_width(LINE_WORDS);

  logic                             ram_avalid;
  logic                             ram_wr;
  logic [ADDR_WIDTH-1:0]            ram_addr;
  logic [LINE_WORDS*WORD_WIDTH-1:0] ram_wdata;
  logic [LINE_WORDS*WORD_WIDTH-1:0] ram_rdata;
  logic                             ram_ack;

  logic                             mem_req;
  logic                             mem_we;
  logic [ADDR_WIDTH+IDX_WIDTH-1:0]  mem_addr;
  logic [WORD_WIDTH-1:0]            mem_wdata;
  logic                             mem_ready;
  logic                             mem_rvalid;
  logic [WORD_WIDTH-1:0]            mem_rdata;

  modport slave (
    input  ram_avalid, ram_wr, ram_addr, ram_wdata, mem_ready, mem_rvalid, mem_rdata,
    output ram_rdata, ram_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ram_avalid, ram_wr, ram_addr, ram_wdata, mem_ready, mem_rvalid, mem_rdata,
    input  ram_rdata, ram_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ram_line_buffer.sv
// LINE_WORDS x WORD_WIDTH line register.
//   load/load_line   : replace the whole line (has priority over word write)
//   wr_en/wr_idx/wr_word : write one word
//   sel_idx/sel_word : combinational word select
//   line             : whole registered line, word i at [i*WORD_WIDTH +: WORD_WIDTH]
module ram_line_buffer #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned IDX_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             not_reset,
  input  logic                             load,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] load_line,
  input  logic                             wr_en,
  input  logic [IDX_WIDTH-1:0]             wr_idx,
  input  logic [WORD_WIDTH-1:0]            wr_word,
  input  logic [IDX_WIDTH-1:0]             sel_idx,
  output logic [WORD_WIDTH-1:0]            sel_word,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] line
);

  logic [LINE_WORDS-1:0][WORD_WIDTH-1:0] words_q, words_d;

  always_comb begin
    words_d = words_q;
    if (load) begin
      words_d = load_line;
    end else if (wr_en) begin
      words_d[wr_idx] = wr_word;
    end
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      words_q <= '0;
    end else begin
      words_q <= words_d;
    end
  end

  assign sel_word = words_q[sel_idx];
  assign line     = words_q;

endmodule

// File: rtl/ram_line_port.sv
// Whole-line RAM port: turns each cache line request into LINE_WORDS single-word
// transactions on the external memory bus. Writes drain the latched eviction line;
// reads issue and collect concurrently, filling ram_rdata word by word, then ack.
//   clk, not_reset : clock, asynchronous active-low reset
//   bus            : ram_line_port_if.slave (cache request/ack + word memory bus)
// Parameters must match those of the connected interface instance.
module ram_line_port
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            not_reset,
  ram_line_port_if.slave  bus
);

  localparam int unsigned IDX_WIDTH = word_idx_width(LINE_WORDS);
  // One extra bit so the LINE_WORDS terminal count is representable.
  localparam int unsigned CNT_WIDTH = IDX_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LINE_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(LINE_WORDS);

  port_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic [CNT_WIDTH-1:0]  icnt_q, icnt_d;  // issue count (write drain or read request)
  logic [CNT_WIDTH-1:0]  rcnt_q, rcnt_d;  // read words received

  logic                  wbuf_load;
  logic                  mem_req_c;
  logic                  mem_we_c;
  logic                  rx_fire;
  logic [WORD_WIDTH-1:0] drain_word;

  logic [LINE_WORDS*WORD_WIDTH-1:0] wbuf_line_unused;
  logic [WORD_WIDTH-1:0]            rbuf_sel_unused;

  // Returned words count only inside a read and only up to a full line.
  assign rx_fire = (state_q == StRead) && bus.mem_rvalid && (rcnt_q < CNT_FULL);

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    icnt_d    = icnt_q;
    rcnt_d    = rcnt_q;
    wbuf_load = 1'b0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.ram_avalid) begin
          line_d    = bus.ram_addr;
          wbuf_load = bus.ram_wr;
          state_d   = bus.ram_wr ? StWrite : StRead;
        end
      end
      StWrite: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        if (bus.mem_ready) begin
          icnt_d = icnt_q + 1'b1;
          if (icnt_q == CNT_LAST) begin
            state_d = StAck;
          end
        end
      end
      StRead: begin
        mem_req_c = (icnt_q < CNT_FULL);
        if (mem_req_c && bus.mem_ready) begin
          icnt_d = icnt_q + 1'b1;
        end
        if (rx_fire) begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == CNT_LAST) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        icnt_d  = '0;
        rcnt_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q <= StIdle;
      line_q  <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Eviction line, latched in IDLE and drained word by word.
  ram_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_wbuf (
    .clk       (clk),
    .not_reset (not_reset),
    .load      (wbuf_load),
    .load_line (bus.ram_wdata),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_word   ('0),
    .sel_idx   (icnt_q[IDX_WIDTH-1:0]),
    .sel_word  (drain_word),
    .line      (wbuf_line_unused)
  );

  // Fill line; kept separate so write bursts never disturb ram_rdata.
  ram_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_rbuf (
    .clk       (clk),
    .not_reset (not_reset),
    .load      (1'b0),
    .load_line ('0),
    .wr_en     (rx_fire),
    .wr_idx    (rcnt_q[IDX_WIDTH-1:0]),
    .wr_word   (bus.mem_rdata),
    .sel_idx   ('0),
    .sel_word  (rbuf_sel_unused),
    .line      (bus.ram_rdata)
  );

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_req_c ? {line_q, icnt_q[IDX_WIDTH-1:0]} : '0;
  assign bus.mem_wdata = mem_we_c ? drain_word : '0;
  assign bus.ram_ack   = (state_q == StAck);

endmodule

// File: tb/tb_ram_line_port.sv
// Directed bench for ram_line_port (default geometry: 8-bit lines, 4 x 8-bit words).
module tb_ram_line_port;

  logic clk = 1'b0;
  logic not_reset;

  always #5 clk = ~clk;

  ram_line_port_if bus ();

  ram_line_port dut (
    .clk       (clk),
    .not_reset (not_reset),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to posedge + 1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; returns inside the ACK cycle with ram_avalid still high.
  task automatic write_line(input logic [7:0] line, input logic [31:0] data,
                            input logic [31:0] keep_rdata);
    bus.ram_avalid = 1'b1;
    bus.ram_wr     = 1'b1;
    bus.ram_addr   = line;
    bus.ram_wdata  = data;
    bus.mem_ready  = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("wr_req", bus.mem_req, 1);
      chk("wr_we", bus.mem_we, 1);
      chk("wr_addr", bus.mem_addr, {line, 2'(c)});
      chk("wr_wdata", bus.mem_wdata, data[c*8 +: 8]);
      chk("wr_no_ack", bus.ram_ack, 0);
      tick();
    end
    #1;
    chk("wr_ack", bus.ram_ack, 1);
    chk("wr_ack_req", bus.mem_req, 0);
    chk("wr_rdata_keep", bus.ram_rdata, keep_rdata);
  endtask

  // Read with 1-cycle memory latency; returns inside the ACK cycle (read cycle 6).
  task automatic read_line(input logic [7:0] line, input logic [31:0] data);
    bus.ram_avalid = 1'b1;
    bus.ram_wr     = 1'b0;
    bus.ram_addr   = line;
    bus.mem_ready  = 1'b1;
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c >= 2 && c <= 5) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data[(c-2)*8 +: 8];
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 8'h00;
      end
      #1;
      if (c <= 4) begin
        chk("rd_req", bus.mem_req, 1);
        chk("rd_we", bus.mem_we, 0);
        chk("rd_addr", bus.mem_addr, {line, 2'(c-1)});
      end else if (c == 5) begin
        chk("rd_req_done", bus.mem_req, 0);
        chk("rd_no_early_ack", bus.ram_ack, 0);
      end else begin
        chk("rd_ack", bus.ram_ack, 1);
        chk("rd_ack_req", bus.mem_req, 0);
        chk("rd_rdata", bus.ram_rdata, data);
      end
      if (c < 6) tick();
    end
  endtask

  // Cache sees the ack and drops its request; checks the following IDLE cycle.
  task automatic release_req();
    tick();
    bus.ram_avalid = 1'b0;
    bus.ram_wr     = 1'b0;
    #1;
    chk("rel_ack_low", bus.ram_ack, 0);
    chk("rel_req_low", bus.mem_req, 0);
  endtask

  logic       st_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] st_idx [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [7:0] st_wd  [7] = '{8'h21, 8'h43, 8'h43, 8'h43, 8'h65, 8'h65, 8'h87};
  int         accepts;

  initial begin
    not_reset      = 1'b0;
    bus.ram_avalid = 1'b0;
    bus.ram_wr     = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    #12;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_ack", bus.ram_ack, 0);
    chk("rst_rdata", bus.ram_rdata, 0);
    @(negedge clk);
    not_reset = 1'b1;
    tick();

    // Line write, mem_ready held high.
    write_line(8'h12, 32'hDDCCBBAA, 32'h0);
    release_req();

    // Line read, memory latency 1.
    read_line(8'h03, 32'h44332211);
    release_req();
    chk("rd_hold", bus.ram_rdata, 32'h44332211);

    // Write with stalls: words held while mem_ready is low.
    bus.ram_avalid = 1'b1;
    bus.ram_wr     = 1'b1;
    bus.ram_addr   = 8'h20;
    bus.ram_wdata  = 32'h87654321;
    tick();
    accepts = 0;
    for (int c = 0; c < 7; c++) begin
      bus.mem_ready = st_rdy[c];
      #1;
      chk("stall_req", bus.mem_req, 1);
      chk("stall_addr", bus.mem_addr, {8'h20, st_idx[c]});
      chk("stall_wdata", bus.mem_wdata, st_wd[c]);
      if (bus.mem_req && bus.mem_ready) accepts++;
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("stall_ack", bus.ram_ack, 1);
    chk("stall_accepts", accepts, 4);
    chk("stall_rdata_keep", bus.ram_rdata, 32'h44332211);
    release_req();

    // Eviction: write then read with ram_avalid held across the ack.
    write_line(8'h05, 32'h0F0E0D0C, 32'h44332211);
    bus.ram_wr   = 1'b0;
    bus.ram_addr = 8'h07;
    tick();
    #1;
    chk("evict_idle_req", bus.mem_req, 0);
    chk("evict_idle_ack", bus.ram_ack, 0);
    chk("evict_rdata_keep", bus.ram_rdata, 32'h44332211);
    read_line(8'h07, 32'hD4C3B2A1);
    release_req();

    // Reset in the middle of a read after two words returned.
    bus.ram_avalid = 1'b1;
    bus.ram_wr     = 1'b0;
    bus.ram_addr   = 8'h0A;
    tick();
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 8'h01;
    tick();
    bus.mem_rdata  = 8'h02;
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("mid_req", bus.mem_req, 1);
    chk("mid_rdata", bus.ram_rdata, 32'hD4C30201);
    not_reset      = 1'b0;
    bus.ram_avalid = 1'b0;
    #1;
    chk("abort_req", bus.mem_req, 0);
    chk("abort_we", bus.mem_we, 0);
    chk("abort_addr", bus.mem_addr, 0);
    chk("abort_wdata", bus.mem_wdata, 0);
    chk("abort_ack", bus.ram_ack, 0);
    chk("abort_rdata", bus.ram_rdata, 0);
    #1;
    not_reset = 1'b1;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 8'h55;
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("late_rdata", bus.ram_rdata, 0);
    chk("late_ack", bus.ram_ack, 0);
    chk("late_req", bus.mem_req, 0);
    read_line(8'h0B, 32'h89ABCDEF);
    release_req();

    // Spurious returned word while idle.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 8'hFF;
    tick();
    tick();
    #1;
    chk("spur_rdata", bus.ram_rdata, 32'h89ABCDEF);
    chk("spur_ack", bus.ram_ack, 0);
    bus.mem_rvalid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_line_port.md
Name: ram_line_port

Overview:
- Downstream neighbour of the cache control unit.
- Accepts whole-line RAM requests (ram_avalid/ram_wr/ram_ack handshake) and turns each into a burst of LINE_WORDS single-word transactions on a narrow external memory bus.
- Writes serialise the evicted line. Reads gather returned words into a line register, then acknowledge the cache.

Parameters:
- ADDR_WIDTH, 8, line address width.
- LINE_WORDS, 4, words per cache line; power of two, 2..16.
- WORD_WIDTH, 8, external memory word width.

Ports:
- clk  in  1  clock.
- not_reset  in  1  reset, asynchronous, active-low.
- ram_avalid  in  1  cache request valid; level, held until ram_ack.
- ram_wr  in  1  1 = line write (eviction), 0 = line read (fill).
- ram_addr  in  ADDR_WIDTH  line address.
- ram_wdata  in  LINE_WORDS*WORD_WIDTH  line to write; word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- ram_rdata  out  LINE_WORDS*WORD_WIDTH  fetched line, registered.
- ram_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  word request valid.
- mem_we  out  1  word write enable.
- mem_addr  out  ADDR_WIDTH+log2(LINE_WORDS)  word address = {line, word index}.
- mem_wdata  out  WORD_WIDTH  write word.
- mem_ready  in  1  memory accepts request when mem_req & mem_ready.
- mem_rvalid  in  1  read word returning; strictly in issue order, latency >= 1.
- mem_rdata  in  WORD_WIDTH  returned word.

Behaviour:
- Reset: state IDLE. mem_req, mem_we, mem_addr, mem_wdata, ram_ack and ram_rdata are 0. Counters are 0.
- States: IDLE, WRITE, READ, ACK.
- IDLE:
  - On ram_avalid=1, latch ram_addr, ram_wr and ram_wdata (writes only) into internal registers.
  - Go to WRITE if ram_wr=1, otherwise READ.
  - Inputs changing after the latch are ignored until the next IDLE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr={line, wcnt}, mem_wdata=latched word wcnt.
  - wcnt increments on each accept (mem_req & mem_ready).
  - Accept of word LINE_WORDS-1 -> ACK.
  - mem_ready low stalls with all outputs held stable.
- READ:
  - mem_req=1 and mem_we=0 while icnt < LINE_WORDS; mem_addr={line, icnt}; icnt increments on accept.
  - Each mem_rvalid writes mem_rdata into line word rcnt and increments rcnt.
  - Issue and collect run concurrently (pipelined).
  - Edge at which the final word is received (rcnt reaches LINE_WORDS) -> ACK.
  - The final-word receive may coincide with any issue cycle.
- ACK:
  - ram_ack=1 for exactly one cycle, mem_req=0, then IDLE. Counters clear.
  - The cache still drives ram_avalid=1 in this cycle; ACK never samples it.
- Back-to-back requests: the cache's write-then-read eviction sequence keeps ram_avalid high across the ack. The following IDLE cycle samples the new request, so the turnaround is ack + 1 idle cycle.
- Minimum latency with mem_ready=1, counted from the IDLE sampling edge:
  - Write: LINE_WORDS request cycles, then ack (ack in cycle LINE_WORDS+1).
  - Read with 1-cycle memory latency: ack in cycle LINE_WORDS+2.
- ram_rdata:
  - Updates only word-by-word during READ.
  - Stable from ACK until the next read's first returned word; write bursts never disturb it.
- mem_rvalid outside READ, or beyond LINE_WORDS words, is ignored.
- Reset mid-burst: immediate return to IDLE and all outputs clear. Late mem_rvalid words from the aborted burst are ignored.
- ram_avalid dropping mid-burst (protocol violation): the burst completes and ack still pulses.
- Counters are log2(LINE_WORDS)+1 bits wide, so the LINE_WORDS terminal value is representable. Word index = low log2(LINE_WORDS) bits.

Decomposition:
- Shared package (cache_pkg): state encodings, the LINE_WORDS/WORD_WIDTH/ADDR_WIDTH defaults, and a word-index width function (clog2) reused by the cache datapath.
- One sub-module, ram_line_buffer: the LINE_WORDS x WORD_WIDTH register with indexed word write (read fill) and indexed word select (write drain).

Test Plan:
- Write, mem_ready=1: ram_addr=8'h12, wdata=32'hDDCCBBAA. Expect:
  - mem_addr 0x48..0x4B carrying AA, BB, CC, DD on consecutive cycles.
  - ram_ack a single pulse in the cycle after the last accept.
- Read, memory latency 1: ram_addr=8'h03, memory returns 11, 22, 33, 44. Expect:
  - mem_addr 0x0C..0x0F.
  - ram_rdata=32'h44332211 at ack, ack in cycle 6.
- mem_ready toggled 1,0,0,1,... during a write: each word is held stable while stalled, with no duplicate or skipped index, and exactly 4 accepts.
- Eviction sequence: write line 0x05, ram_avalid kept high and ram_wr dropped at the ack. Expect:
  - A read of line 0x07 starts after exactly one IDLE cycle.
  - ram_rdata untouched by the write.
- not_reset pulsed after 2 read words returned: outputs zero immediately. Then:
  - A late mem_rvalid is ignored.
  - A subsequent read completes with correct data.
- Spurious mem_rvalid=1 with data 0xFF while IDLE: ram_rdata unchanged and no ram_ack.
